fir_mac_seq: RTL and testbench
==============================

// Module: fir_mac_seq
// PURPOSE
//  Initiator side of the FIR coefficient ROM interface. Accepts one input
//  sample per valid/ready handshake and shifts it into an 8-tap delay line.
//  Walks ROM addresses 0..7 and multiply-accumulates each returned coefficient
//  with the matching delayed sample. Presents the 8-tap sum on a valid/ready
//  output. Sits between the sample source and the FIR output sink, driving the
//  coefficient ROM's en/addr and consuming its registered rom_out.
// PARAMETERS
//  data_width   8    unsigned input sample width
//  coeff_width  8    unsigned coefficient width; must match the ROM's rom_out
//  out_width    data_width+coeff_width+3 (19)   accumulator/output width; no overflow possible
// PORTS
//  clock     in   1            rising-edge clock
//  reset     in   1            asynchronous, active-high; clears all state
//  in_valid  in   1            sample available
//  in_data   in   data_width   sample value (unsigned)
//  in_ready  out  1            block can accept a sample (IDLE only)
//  rom_en    out  1            ROM read enable
//  rom_addr  out  3            ROM tap address
//  rom_out   in   coeff_width  ROM data; registered, valid 1 cycle after en/addr; 0 when en was 0
//  out_valid out  1            out_data holds a finished sum
//  out_data  out  out_width    y = sum_{k=0..7} coeff[k]*x[n-k]
//  out_ready in   1            sink accepts out_data
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, delay line x[0..7]=0, acc=0, out_data=0,
//   out_valid=0, rom_en=0, rom_addr=0, tap counter=0. in_ready=1 once reset deasserts.
//  FSM: IDLE -> RUN -> DRAIN -> DONE -> IDLE.
//  IDLE: in_ready=1, rom_en=0. On in_valid&in_ready at edge T:
//   x[0]<=in_data, x[k]<=x[k-1] (k=1..7), acc<=0, cnt<=0, go RUN.
//  RUN (cycles T+1..T+8): rom_en=1, rom_addr=cnt, cnt increments 0..7.
//   Go DRAIN after cnt==7.
//  The tap index is pipelined one stage alongside the ROM latency. In each cycle
//   T+2..T+9: acc <= acc + rom_out * x[idx_d1], full out_width precision, unsigned.
//  DRAIN (cycle T+9): rom_en=0, rom_addr=0. Final accumulate happens this cycle.
//   At the edge: out_data<=final sum, out_valid<=1, go DONE.
//  DONE: out_valid=1 from cycle T+10. out_data stable until out_valid&out_ready.
//   At that edge: out_valid<=0, go IDLE; in_ready=1 the following cycle.
//  Latency: accept edge T -> out_valid high in cycle T+10 (10 clocks).
//   Throughput: 1 sample per 11 cycles minimum.
//  in_ready=0 in RUN/DRAIN/DONE. in_valid/in_data are ignored there; the delay line
//   does not change.
//  out_ready is ignored unless out_valid=1. A sample cannot be accepted in the same
//   cycle as the output handshake.
//  rom_addr=0 whenever rom_en=0. rom_addr never exceeds 7. cnt wraps to 0 on leaving RUN.
//  Reset mid-RUN/DONE: the in-flight result is discarded and the delay line is zeroed.
//   The first post-reset output uses only the new sample.
// TESTING
//  (ROM coeffs 8,7,6,5,4,3,2,1 at addr 0..7)
//  Impulse: in 1 then seven 0s, out_ready=1 -> out_data = 8,7,6,5,4,3,2,1; 9th sample 0 -> 0.
//  Step: eight samples of 255 -> out_data = 2040,3825,5355,6630,7650,8415,8925,9180.
//   Max 9180 with no truncation.
//  Timing: accept at edge T -> rom_en=1 with rom_addr 0..7 in cycles T+1..T+8;
//   rom_en=0 at T+9; out_valid=1 at T+10.
//  Backpressure: hold out_ready=0 for 5 cycles while driving in_valid=1 with
//   in_data=99 -> out_valid/out_data held, in_ready=0, 99 not accepted.
//   Release -> IDLE, then 99 accepted.
//  Reset mid-RUN (cnt=4): assert reset asynchronously -> rom_en, out_valid,
//   out_data=0 immediately. After release, feed 3 -> out_data=24.

Source files
------------

// File: rtl/fir_mac_seq.sv
`default_nettype none
// ============================================================================
//  Module      : fir_mac_seq
//  Description : Sequential 8-tap FIR. Accepts one sample per valid/ready
//                handshake, walks the coefficient ROM over taps 0..7 and
//                multiply-accumulates each coefficient with its delayed
//                sample, then presents the sum on a valid/ready output.
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_mac_seq #(
    parameter int DATA_WIDTH  = 8,
    parameter int COEFF_WIDTH = 8,
    parameter int OUT_WIDTH   = DATA_WIDTH + COEFF_WIDTH + 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [DATA_WIDTH-1:0]  in_data,
    output logic                   in_ready,
    output logic                   rom_en,
    output logic [2:0]             rom_addr,
    input  logic [COEFF_WIDTH-1:0] rom_out,
    output logic                   out_valid,
    output logic [OUT_WIDTH-1:0]   out_data,
    input  logic                   out_ready
);

    localparam int C_TAPS      = 8;
    localparam int C_PROD_W    = DATA_WIDTH + COEFF_WIDTH;
    localparam int C_GUARD_W   = OUT_WIDTH - C_PROD_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;

    logic [DATA_WIDTH-1:0]   r_x [0:C_TAPS-1];
    logic [2:0]              r_cnt;
    logic [2:0]              r_idx_d1;
    logic                    r_acc_vld;
    logic [OUT_WIDTH-1:0]    r_acc;
    logic [OUT_WIDTH-1:0]    r_out_data;
    logic                    r_out_valid;

    logic                    w_accept;
    logic [DATA_WIDTH-1:0]   w_x_sel;
    logic [C_PROD_W-1:0]     w_prod;
    logic [OUT_WIDTH-1:0]    w_sum;

    // Handshake and ROM drive are pure functions of the state and tap counter
    assign in_ready  = (r_state == S_IDLE);
    assign w_accept  = in_valid && (r_state == S_IDLE);
    assign rom_en    = (r_state == S_RUN);
    assign rom_addr  = (r_state == S_RUN) ? r_cnt : 3'd0;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

    // The ROM answers one cycle late, so the delayed tap index selects the sample
    assign w_x_sel = r_x[r_idx_d1];
    assign w_prod  = {{COEFF_WIDTH{1'b0}}, w_x_sel} * {{DATA_WIDTH{1'b0}}, rom_out};
    assign w_sum   = r_acc + {{C_GUARD_W{1'b0}}, w_prod};

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: IDLE -> RUN -> DRAIN -> DONE -> IDLE
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt == 3'd7) begin
                    w_next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_next_state = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Delay line: shifts only on an accepted sample, newest sample in slot 0
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < C_TAPS; k++) begin
                r_x[k] <= '0;
            end
        end else if (w_accept) begin
            r_x[0] <= in_data;
            for (int k = 1; k < C_TAPS; k++) begin
                r_x[k] <= r_x[k-1];
            end
        end
    end

    // Tap counter walks 0..7 while in RUN and naturally wraps to 0 on exit
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt <= 3'd0;
        end else if (w_accept) begin
            r_cnt <= 3'd0;
        end else if (r_state == S_RUN) begin
            r_cnt <= r_cnt + 3'd1;
        end
    end

    // Tap index and accumulate-enable follow the ROM read by one cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_idx_d1  <= 3'd0;
            r_acc_vld <= 1'b0;
        end else begin
            r_idx_d1  <= (r_state == S_RUN) ? r_cnt : 3'd0;
            r_acc_vld <= (r_state == S_RUN);
        end
    end

    // Accumulator: cleared on accept, adds one product per returned coefficient
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_acc <= '0;
        end else if (w_accept) begin
            r_acc <= '0;
        end else if (r_acc_vld) begin
            r_acc <= w_sum;
        end
    end

    // Output register: captures the final sum in DRAIN, holds it until taken
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else if (r_state == S_DRAIN) begin
            r_out_data  <= w_sum;
            r_out_valid <= 1'b1;
        end else if ((r_state == S_DONE) && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fir_mac_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fir_mac_seq
//  Description : Directed, table-driven bench for fir_mac_seq with a
//                registered coefficient ROM model (coeffs 8..1 at addr 0..7).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_mac_seq;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_ready;
    logic        rom_en;
    logic [2:0]  rom_addr;
    logic [7:0]  rom_out;
    logic        out_valid;
    logic [18:0] out_data;
    logic        out_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  din;
        logic [18:0] exp;
    } vec_t;

    vec_t vecs [0:16];

    fir_mac_seq dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .rom_en    (rom_en),
        .rom_addr  (rom_addr),
        .rom_out   (rom_out),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    always #5 clock = ~clock;

    // Coefficient ROM model: registered read, zero when not enabled
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rom_out <= 8'd0;
        end else if (rom_en) begin
            rom_out <= 8'd8 - {5'd0, rom_addr};
        end else begin
            rom_out <= 8'd0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge right after the accept edge T; checks T+1..T+10
    task automatic run_after_accept(input logic [18:0] exp);
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            check("rom_en_run", {31'd0, rom_en}, 32'd1);
            check("rom_addr_run", {29'd0, rom_addr}, k);
            check("in_ready_run", {31'd0, in_ready}, 32'd0);
        end
        @(negedge clock);
        check("rom_en_drain", {31'd0, rom_en}, 32'd0);
        check("rom_addr_drain", {29'd0, rom_addr}, 32'd0);
        check("out_valid_drain", {31'd0, out_valid}, 32'd0);
        @(negedge clock);
        check("out_valid_done", {31'd0, out_valid}, 32'd1);
        check("out_data", {13'd0, out_data}, {13'd0, exp});
    endtask

    // From a negedge: wait for in_ready (bounded), then accept din at the next edge
    task automatic accept_sample(input logic [7:0] din);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("in_ready_wait", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = din;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_data  = 8'd0;
    endtask

    // At the negedge where out_valid is high: take the output and confirm return to IDLE
    task automatic finish_out();
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        @(negedge clock);
        check("out_valid_cleared", {31'd0, out_valid}, 32'd0);
        check("in_ready_idle", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        // Impulse response, then one trailing zero
        vecs[0] = '{8'd1, 19'd8};
        vecs[1] = '{8'd0, 19'd7};
        vecs[2] = '{8'd0, 19'd6};
        vecs[3] = '{8'd0, 19'd5};
        vecs[4] = '{8'd0, 19'd4};
        vecs[5] = '{8'd0, 19'd3};
        vecs[6] = '{8'd0, 19'd2};
        vecs[7] = '{8'd0, 19'd1};
        vecs[8] = '{8'd0, 19'd0};
        // Full-scale step response
        vecs[9]  = '{8'd255, 19'd2040};
        vecs[10] = '{8'd255, 19'd3825};
        vecs[11] = '{8'd255, 19'd5355};
        vecs[12] = '{8'd255, 19'd6630};
        vecs[13] = '{8'd255, 19'd7650};
        vecs[14] = '{8'd255, 19'd8415};
        vecs[15] = '{8'd255, 19'd8925};
        vecs[16] = '{8'd255, 19'd9180};

        // Reset state
        #12;
        check("rst_rom_en", {31'd0, rom_en}, 32'd0);
        check("rst_rom_addr", {29'd0, rom_addr}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {13'd0, out_data}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Table-driven impulse and step
        for (int i = 0; i <= 16; i++) begin
            accept_sample(vecs[i].din);
            run_after_accept(vecs[i].exp);
            finish_out();
        end

        // Backpressure: x = {0, 255 x7} -> 255*28 = 7140
        accept_sample(8'd0);
        run_after_accept(19'd7140);
        in_valid = 1'b1;
        in_data  = 8'd99;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_out_data", {13'd0, out_data}, 32'd7140);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_rom_en", {31'd0, rom_en}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        @(negedge clock);
        check("bp_release_idle", {31'd0, in_ready}, 32'd1);
        check("bp_release_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_data  = 8'd0;
        // x = {99, 0, 255 x6} -> 792 + 255*21 = 6147
        run_after_accept(19'd6147);
        finish_out();

        // Reset in the middle of RUN at tap 4
        accept_sample(8'd7);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
        end
        check("mid_run_addr", {29'd0, rom_addr}, 32'd4);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_rom_en", {31'd0, rom_en}, 32'd0);
        check("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("async_rst_out_data", {13'd0, out_data}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        accept_sample(8'd3);
        run_after_accept(19'd24);
        finish_out();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
